mcm_tap_sequencer: RTL

//  Time-multiplexes one shared 16-output MCM (8-bit X -> 16 signed 16-bit multiples) across the NTAPS taps
//  of an angular-intra interpolation filter. Streams reference samples into the MCM one per cycle and accumulates
//  the 16 returned products per lane. Once all taps are in, emits 16 rounded, clipped 8-bit predicted samples.

---
 rtl/mcm_tap_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mcm_tap_sequencer.sv
// mcm_tap_sequencer: streams reference samples through one shared MCM, accumulates NTAPS tap products per lane,
// then emits LANES rounded, clipped 8-bit predicted samples.
// Ports: clk, rst (sync, active-high), flush; in_valid/in_ready/in_sample (upstream samples);
//   mcm_x -> MCM operand, mcm_y <- MCM products (16 signed bits per lane);
//   out_valid/out_ready/out_pred (downstream predictions); tap_idx (coefficient-set select); busy.
// Option: MCM_SEQ_REG_IN_EN registers the accepted sample into mcm_x and accumulates one cycle later.
module mcm_tap_sequencer #(
    parameter int NTAPS = 4,
    parameter int LANES = 16,
    parameter int SHIFT = 6,
    parameter int ACC_W = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_sample,
    output logic [7:0]               mcm_x,
    input  logic [16*LANES-1:0]      mcm_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*LANES-1:0]       out_pred,
    output logic [$clog2(NTAPS)-1:0] tap_idx,
    output logic                     busy
);

    localparam int TW = $clog2(NTAPS);
    localparam logic [TW-1:0] LAST_TAP = TW'(NTAPS - 1);
    localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1 << (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(255);

    typedef enum logic {S_ACCUM, S_OUT} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [TW-1:0]           r_tap_cnt;
    logic signed [ACC_W-1:0] r_acc [LANES];
    logic signed [ACC_W-1:0] w_sum [LANES];
    logic [8*LANES-1:0]      r_pred;
    logic                    w_accept;
    logic                    w_take;
    logic                    w_first;
    logic                    w_last;
    logic                    w_stall;
    logic                    w_stg_busy;

    function automatic logic signed [ACC_W-1:0] f_sext(input logic [15:0] y);
        return {{(ACC_W-16){y[15]}}, y};
    endfunction

    // Round half up, arithmetic shift, then saturate to 0..255.
    function automatic logic [7:0] f_clip(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = (v + RND) >>> SHIFT;
        if (s[ACC_W-1])
            return 8'd0;
        else if (s > MAXV)
            return 8'd255;
        else
            return s[7:0];
    endfunction

`ifdef MCM_SEQ_REG_IN_EN
    logic       r_stg_vld;
    logic       r_stg_first;
    logic       r_stg_last;
    logic [7:0] r_mcm_x;

    // One-stage operand register; products for it return the following cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_stg_vld   <= 1'b0;
            r_stg_first <= 1'b0;
            r_stg_last  <= 1'b0;
            r_mcm_x     <= 8'd0;
        end else begin
            r_stg_vld   <= w_accept;
            r_stg_first <= w_accept && (r_tap_cnt == '0);
            r_stg_last  <= w_accept && (r_tap_cnt == LAST_TAP);
            r_mcm_x     <= w_accept ? in_sample : 8'd0;
        end
    end

    assign w_take     = r_stg_vld;
    assign w_first    = r_stg_first;
    assign w_last     = r_stg_last;
    // Last tap still in flight: hold off the next group until OUT is entered.
    assign w_stall    = r_stg_vld && r_stg_last;
    assign w_stg_busy = r_stg_vld;
    assign mcm_x      = r_mcm_x;
`else
    assign w_take     = w_accept;
    assign w_first    = (r_tap_cnt == '0);
    assign w_last     = (r_tap_cnt == LAST_TAP);
    assign w_stall    = 1'b0;
    assign w_stg_busy = 1'b0;
    assign mcm_x      = (r_state == S_ACCUM) ? in_sample : 8'd0;
`endif

    assign in_ready = (r_state == S_ACCUM) && !w_stall && !flush;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_sum[i] = w_first ? f_sext(mcm_y[16*i +: 16])
                               : r_acc[i] + f_sext(mcm_y[16*i +: 16]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_ACCUM;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ACCUM: if (w_take && w_last) w_state_nxt = S_OUT;
            S_OUT:   if (out_ready) w_state_nxt = S_ACCUM;
            default: w_state_nxt = S_ACCUM;
        endcase
        if (flush)
            w_state_nxt = S_ACCUM;
    end

    always_ff @(posedge clk) begin
        if (rst || flush)
            r_tap_cnt <= '0;
        else if (w_accept)
            r_tap_cnt <= (r_tap_cnt == LAST_TAP) ? '0 : r_tap_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < LANES; i++)
                r_acc[i] <= '0;
        end else if (w_take) begin
            for (int i = 0; i < LANES; i++)
                r_acc[i] <= w_sum[i];
        end
    end

    // Result is captured on the final tap so it is ready on OUT entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred <= '0;
        end else if (!flush && w_take && w_last) begin
            for (int i = 0; i < LANES; i++)
                r_pred[8*i +: 8] <= f_clip(w_sum[i]);
        end
    end

    assign out_valid = (r_state == S_OUT);
    assign out_pred  = r_pred;
    assign tap_idx   = r_tap_cnt;
    assign busy      = (r_tap_cnt != '0) || w_stg_busy || (r_state == S_OUT);

endmodule
